prog_loader: RTL and testbench

- Writer side of the instruction-memory interface.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words sequentially into instruction memory while holding the core in reset.
- Releases the core once the frame checksum verifies, so a program image can be loaded without resynthesis.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader_word_assembler.sv | 34 +++
 rtl/prog_loader.sv | 138 +++++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader shared types and frame constants.
// Imported by the loader top and its word assembler.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] LAST_BYTE =
    2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream receive and instruction-memory write bundle.
// master = stream source / memory, slave = loader.
interface prog_loader_if #(
  parameter int ADDR_W = 32
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Little-endian 8-to-32 shift register.
// word_valid pulses the cycle after the 4th byte.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_valid
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_idx   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
      end else if (byte_valid) begin
        // new byte enters at the top; byte 0 ends up in 7:0
        word       <= {byte_in, word[31:8]};
        byte_idx   <= byte_idx + 2'd1;
        word_valid <= (byte_idx == LAST_BYTE);
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader for instruction memory.
// Holds the core in reset until a checksummed image lands.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              MAX_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  prog_loader_if.slave bus,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  state_t            state;
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic [15:0]       n;
  logic [15:0]       words;
  logic [ADDR_W-1:0] addr;
  logic              rx_ready;
  logic              xfer;
  logic              restart;
  logic [15:0]       len;
  logic [1:0]        byte_idx;
  logic              word_valid;
  logic [31:0]       word;

  assign xfer    = bus.rx_valid & rx_ready;
  assign restart = start & ((state == S_IDLE) |
                            (state == S_DONE) |
                            (state == S_ERR));
  assign len     = {bus.rx_data, len_lo};

  assign bus.rx_ready = rx_ready;
  assign bus.wr_en    = word_valid;
  assign bus.wr_addr  = addr;
  assign bus.wr_data  = word;

  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (restart),
    .byte_in    (bus.rx_data),
    .byte_valid (xfer && (state == S_DATA)),
    .byte_idx   (byte_idx),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      addr      <= BASE_ADDR;
      core_hold <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      len_lo    <= '0;
      csum      <= '0;
      n         <= '0;
      words     <= '0;
    end else begin
      if (word_valid)
        addr <= addr + ADDR_W'(BYTES_PER_WORD);
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_LEN0;
            rx_ready  <= 1'b1;
            csum      <= '0;
            words     <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
          end
        end
        S_LEN0: begin
          if (xfer) begin
            len_lo <= bus.rx_data;
            csum   <= csum ^ bus.rx_data;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            n    <= len;
            csum <= csum ^ bus.rx_data;
            if (32'(len) > 32'(MAX_WORDS)) begin
              state    <= S_ERR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else if (len == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
              addr  <= BASE_ADDR;
            end
          end
        end
        S_DATA: begin
          // leave on the last byte so the write cycle can
          // overlap the checksum byte without a stall
          if (xfer) begin
            csum <= csum ^ bus.rx_data;
            if (byte_idx == LAST_BYTE) begin
              words <= words + 16'd1;
              if (words == n - 16'd1)
                state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            rx_ready <= 1'b0;
            if (bus.rx_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame-level model
// plus per-cycle comparison of writes and status.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];
  localparam int MAXW = 1024;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic core_hold;
  logic done;
  logic error;

  prog_loader_if bus ();

  prog_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  bit exp_done = 1'b0;
  bit exp_err  = 1'b0;
  bit exp_hold = 1'b1;
  int wr_issued = 0;
  int wr_seen   = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] act_addr[$];
  logic [31:0] act_data[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("wr_en", bus.wr_en, wr_issued > wr_seen);
    if (bus.wr_en) begin
      act_addr.push_back(bus.wr_addr);
      act_data.push_back(bus.wr_data);
      if (wr_issued > wr_seen && exp_addr.size() > 0) begin
        chk("wr_addr", bus.wr_addr, exp_addr.pop_front());
        chk("wr_data", bus.wr_data, exp_data.pop_front());
      end
      wr_seen++;
    end
    chk("done", done, exp_done);
    chk("error", error, exp_err);
    chk("core_hold", core_hold, exp_hold);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 50) begin
      tick();
      t++;
    end
    chk("rx_ready_wait", bus.rx_ready, 1'b1);
    if (bus.rx_ready) tick();
    bus.rx_valid = 1'b0;
  endtask

  function automatic bq_t make_frame(input logic [31:0] ws[$]);
    bq_t f;
    logic [7:0] x;
    logic [15:0] n;
    n = 16'(ws.size());
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    foreach (ws[i])
      for (int b = 0; b < 4; b++)
        f.push_back(ws[i][8*b +: 8]);
    x = 8'h00;
    foreach (f[i]) x ^= f[i];
    f.push_back(x);
    return f;
  endfunction

  // Model: derive writes and final status from frame rules.
  task automatic run_frame(input bq_t fr, input bit gaps,
                           input bit poke);
    int n;
    int k;
    int d;
    logic [7:0] x;
    logic [31:0] w;
    n = 0;
    k = 0;
    x = 8'h00;
    w = '0;
    act_addr.delete();
    act_data.delete();
    pulse_start();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_hold = 1'b1;
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps && i > 0)
        repeat ($urandom_range(0, 3)) tick();
      if (poke && (i == 4 || i == 9)) pulse_start();
      send_byte(fr[i]);
      if (i == 1) begin
        n = {fr[1], fr[0]};
        if (n > MAXW) begin
          exp_err = 1'b1;
          break;
        end
      end else if (i >= 2 && i < 2 + 4 * n) begin
        d = i - 2;
        w[8 * (d % 4) +: 8] = fr[i];
        if (d % 4 == 3) begin
          exp_addr.push_back(32'(4 * k));
          exp_data.push_back(w);
          k++;
          wr_issued++;
        end
      end else if (i == 2 + 4 * n) begin
        if (fr[i] == x) begin
          exp_done = 1'b1;
          exp_hold = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end
      x ^= fr[i];
    end
    repeat (2) tick();
  endtask

  initial begin
    bq_t fr;
    logic [31:0] ws[$];
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) tick();
    chk("rst_rx_ready", bus.rx_ready, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    reset = 1'b1;
    tick();

    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    reset = 1'b0;
    #2;
    chk("midrst_rx_ready", bus.rx_ready, 1'b0);
    chk("midrst_hold", core_hold, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_error", error, 1'b0);
    chk("midrst_wr_en", bus.wr_en, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    run_frame(fr, 1'b0, 1'b0);
    chk("good_done", done, 1'b1);
    chk("good_hold", core_hold, 1'b0);
    chk("good_nwr", act_addr.size(), 2);
    if (act_addr.size() == 2) begin
      chk("good_a0", act_addr[0], 32'h0);
      chk("good_d0", act_data[0], 32'h00000013);
      chk("good_a1", act_addr[1], 32'h4);
      chk("good_d1", act_data[1], 32'h00100093);
    end

    fr[10] = 8'h00;
    run_frame(fr, 1'b0, 1'b0);
    chk("bad_error", error, 1'b1);
    chk("bad_done", done, 1'b0);
    chk("bad_hold", core_hold, 1'b1);
    chk("bad_nwr", act_addr.size(), 2);

    fr = '{8'h01, 8'h04};
    run_frame(fr, 1'b0, 1'b0);
    chk("len_error", error, 1'b1);
    chk("len_rx_ready", bus.rx_ready, 1'b0);
    chk("len_nwr", act_addr.size(), 0);

    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(fr, 1'b0, 1'b0);
    chk("zero_done", done, 1'b1);
    chk("zero_nwr", act_addr.size(), 0);

    ws = '{32'hDEADBEEF, 32'h01234567, 32'hA55A0FF0};
    fr = make_frame(ws);
    run_frame(fr, 1'b1, 1'b1);
    chk("gap_done", done, 1'b1);
    chk("gap_nwr", act_addr.size(), 3);
    if (act_addr.size() == 3) begin
      chk("gap_a2", act_addr[2], 32'h8);
      chk("gap_d0", act_data[0], 32'hDEADBEEF);
      chk("gap_d2", act_data[2], 32'hA55A0FF0);
    end

    ws = '{32'h00500113, 32'hFFF10093};
    fr = make_frame(ws);
    run_frame(fr, 1'b0, 1'b0);
    chk("re_done", done, 1'b1);
    chk("re_hold", core_hold, 1'b0);
    chk("re_nwr", act_addr.size(), 2);
    if (act_addr.size() == 2) begin
      chk("re_a1", act_addr[1], 32'h4);
      chk("re_d1", act_data[1], 32'hFFF10093);
    end

    repeat (3) tick();
    chk("exp_q_empty", exp_addr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
